// File: rtl/adc_scan_sequencer.sv
// Scans three channels of a 3-wire serial ADC per burst (four pipelined 16-SCK frames, first one dummy).
// Optional per-slot threshold compare onto line_bits is enabled with `define ADC_THRESH_EN.
module adc_scan_sequencer #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [2:0]  cfg_ch0,
    input  logic [2:0]  cfg_ch1,
    input  logic [2:0]  cfg_ch2,
    input  logic [11:0] thresh,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  result_slot,
    output logic [11:0] result_data,
    output logic [11:0] sample0,
    output logic [11:0] sample1,
    output logic [11:0] sample2,
    output logic        scan_done,
    output logic [2:0]  line_bits
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_TAIL  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        din_q, din_d;
    logic        busy_q, busy_d;
    logic [2:0]  ch0_q, ch0_d;
    logic [2:0]  ch1_q, ch1_d;
    logic [2:0]  ch2_q, ch2_d;
    logic [11:0] shift_q, shift_d;
    logic [11:0] pend0_q, pend0_d;
    logic [11:0] pend1_q, pend1_d;
    logic [11:0] pend2_q, pend2_d;
    logic        rv_q, rv_d;
    logic [1:0]  slot_q, slot_d;
    logic [11:0] rdata_q, rdata_d;
    logic [11:0] sample0_q, sample0_d;
    logic [11:0] sample1_q, sample1_d;
    logic [11:0] sample2_q, sample2_d;
    logic        done_q, done_d;
    logic [2:0]  line_q, line_d;

    logic        cnt_last;
    logic [1:0]  frame;
    logic [3:0]  bit_k;
    logic [11:0] word_in;
    logic [5:0]  bit_next;
    logic [2:0]  line_new;

    // Address bit driven during bit k of a frame; frame 3 re-addresses slot 0 so the pipeline drains.
    function automatic logic addr_bit(input logic [5:0] idx, input logic [2:0] c0,
                                      input logic [2:0] c1, input logic [2:0] c2);
        logic [2:0] a;
        logic       b;
        case (idx[5:4])
            2'd1:    a = c1;
            2'd2:    a = c2;
            default: a = c0;
        endcase
        case (idx[3:0])
            4'd2:    b = a[2];
            4'd3:    b = a[1];
            4'd4:    b = a[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign cnt_last = (cnt_q == DIV_LAST);
    assign frame    = bit_q[5:4];
    assign bit_k    = bit_q[3:0];
    assign word_in  = {shift_q[10:0], adc_dout};
    assign bit_next = bit_q + 6'd1;

`ifdef ADC_THRESH_EN
    assign line_new = {(pend2_q > thresh), (pend1_q > thresh), (pend0_q > thresh)};
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign line_new      = 3'b000;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_last ? 8'd0 : cnt_q + 8'd1;
        bit_d     = bit_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        din_d     = din_q;
        busy_d    = busy_q;
        ch0_d     = ch0_q;
        ch1_d     = ch1_q;
        ch2_d     = ch2_q;
        shift_d   = shift_q;
        pend0_d   = pend0_q;
        pend1_d   = pend1_q;
        pend2_d   = pend2_q;
        rv_d      = 1'b0;
        slot_d    = slot_q;
        rdata_d   = rdata_q;
        sample0_d = sample0_q;
        sample1_d = sample1_q;
        sample2_d = sample2_q;
        done_d    = 1'b0;
        line_d    = line_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    ch0_d   = cfg_ch0;
                    ch1_d   = cfg_ch1;
                    ch2_d   = cfg_ch2;
                end
            end

            ST_SETUP: begin
                if (cnt_last) begin
                    state_d = ST_XFER;
                    sck_d   = 1'b0;
                    bit_d   = 6'd0;
                    din_d   = addr_bit(6'd0, ch0_q, ch1_q, ch2_q);
                end
            end

            ST_XFER: begin
                if (cnt_last) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (bit_k >= 4'd4) begin
                            shift_d = word_in;
                        end
                        // result_valid is a one-clock strobe with no backpressure; consumers must take it.
                        if (bit_k == 4'd15 && frame != 2'd0) begin
                            rv_d    = 1'b1;
                            slot_d  = frame - 2'd1;
                            rdata_d = word_in;
                            case (frame)
                                2'd1:    pend0_d = word_in;
                                2'd2:    pend1_d = word_in;
                                default: pend2_d = word_in;
                            endcase
                        end
                    end else if (bit_q == 6'd63) begin
                        state_d = ST_TAIL;
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_next;
                        din_d = addr_bit(bit_next, ch0_q, ch1_q, ch2_q);
                    end
                end
            end

            ST_TAIL: begin
                if (cnt_last) begin
                    state_d   = ST_GAP;
                    cs_n_d    = 1'b1;
                    din_d     = 1'b0;
                    done_d    = 1'b1;
                    sample0_d = pend0_q;
                    sample1_d = pend1_q;
                    sample2_d = pend2_q;
                    line_d    = line_new;
                end
            end

            ST_GAP: begin
                // The scan_done clock is the first of the CLK_DIV chip-select-high clocks.
                if (cnt_q == 8'd0 && !continuous) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_last) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    ch0_d   = cfg_ch0;
                    ch1_d   = cfg_ch1;
                    ch2_d   = cfg_ch2;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                cs_n_d  = 1'b1;
                sck_d   = 1'b1;
                din_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            bit_q     <= 6'd0;
            cs_n_q    <= 1'b1;
            sck_q     <= 1'b1;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
            ch0_q     <= 3'd0;
            ch1_q     <= 3'd0;
            ch2_q     <= 3'd0;
            shift_q   <= 12'd0;
            pend0_q   <= 12'd0;
            pend1_q   <= 12'd0;
            pend2_q   <= 12'd0;
            rv_q      <= 1'b0;
            slot_q    <= 2'd0;
            rdata_q   <= 12'd0;
            sample0_q <= 12'd0;
            sample1_q <= 12'd0;
            sample2_q <= 12'd0;
            done_q    <= 1'b0;
            line_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            cs_n_q    <= cs_n_d;
            sck_q     <= sck_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            ch2_q     <= ch2_d;
            shift_q   <= shift_d;
            pend0_q   <= pend0_d;
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
            rv_q      <= rv_d;
            slot_q    <= slot_d;
            rdata_q   <= rdata_d;
            sample0_q <= sample0_d;
            sample1_q <= sample1_d;
            sample2_q <= sample2_d;
            done_q    <= done_d;
            line_q    <= line_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sck      = sck_q;
    assign adc_din      = din_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign result_slot  = slot_q;
    assign result_data  = rdata_q;
    assign sample0      = sample0_q;
    assign sample1      = sample1_q;
    assign sample2      = sample2_q;
    assign scan_done    = done_q;
    assign line_bits    = line_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: behavioural ADC on the serial bus, table of single scans,
// plus sequences for start-while-busy, continuous mode and reset mid-scan.
module tb_adc_scan_sequencer;
    localparam int CLK_DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [2:0]  cfg_ch0, cfg_ch1, cfg_ch2;
    logic [11:0] thresh;
    logic        adc_dout;
    logic        adc_cs_n, adc_sck, adc_din, busy, result_valid, scan_done;
    logic [1:0]  result_slot;
    logic [11:0] result_data, sample0, sample1, sample2;
    logic [2:0]  line_bits;

    adc_scan_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .cfg_ch0(cfg_ch0), .cfg_ch1(cfg_ch1), .cfg_ch2(cfg_ch2), .thresh(thresh),
        .adc_dout(adc_dout), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_din(adc_din),
        .busy(busy), .result_valid(result_valid), .result_slot(result_slot),
        .result_data(result_data), .sample0(sample0), .sample1(sample1), .sample2(sample2),
        .scan_done(scan_done), .line_bits(line_bits)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: edges of adc_sck seen one clk late; data = 0x100*addr + 0x0DA of the previous frame
    logic        sck_prev = 1'b1;
    logic        cs_prev = 1'b1;
    logic [3:0]  kk = 4'd15;
    logic [2:0]  cur_addr = 3'd0;
    logic [2:0]  prev_addr = 3'd0;
    logic [15:0] model_word = 16'd0;
    logic [15:0] frame_word;
    int          rise_cnt = 0;
    logic [2:0]  dec_q[$];

    assign frame_word = {4'h0, 12'h100 * {9'd0, prev_addr} + 12'h0DA};

    always @(posedge clk) begin
        sck_prev <= adc_sck;
        cs_prev  <= adc_cs_n;
        if (!rst_n) begin
            kk        <= 4'd15;
            prev_addr <= 3'd0;
            cur_addr  <= 3'd0;
            adc_dout  <= 1'b0;
        end else begin
            if (cs_prev && !adc_cs_n) begin
                kk       <= 4'd15;
                rise_cnt <= 0;
                dec_q.delete();
            end
            if (!adc_cs_n && sck_prev && !adc_sck) begin
                kk <= kk + 4'd1;
                if (kk == 4'd15) begin
                    model_word <= frame_word;
                    adc_dout   <= frame_word[15];
                end else begin
                    adc_dout <= model_word[4'd14 - kk];
                end
            end
            if (!adc_cs_n && !sck_prev && adc_sck) begin
                rise_cnt <= rise_cnt + 1;
                if (kk >= 4'd2 && kk <= 4'd4) cur_addr <= {cur_addr[1:0], adc_din};
                if (kk == 4'd15) begin
                    dec_q.push_back(cur_addr);
                    prev_addr <= cur_addr;
                end
            end
        end
    end

    // scoreboard
    logic [13:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cs_low_cnt, rv_cnt, done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [13:0] e;
        @(negedge clk);
        if (!adc_cs_n) cs_low_cnt++;
        if (scan_done) done_cnt++;
        if (result_valid) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                check("result_unexpected", {18'd0, result_slot, result_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("result", {18'd0, result_slot, result_data}, {18'd0, e});
            end
        end
    endtask

    typedef struct {
        logic [2:0]  ch0, ch1, ch2;
        logic [11:0] th;
        logic [11:0] s0, s1, s2;
        logic [2:0]  lb;
    } vec_t;
    vec_t vecs[4];

    task automatic check_lb(input string name, input logic [2:0] exp_lb);
`ifdef ADC_THRESH_EN
        check(name, {29'd0, line_bits}, {29'd0, exp_lb});
`else
        check(name, {29'd0, line_bits}, {29'd0, exp_lb & 3'b000});
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int t0;
        int tdone;
        logic [2:0] exp_addr[4];
        cfg_ch0 = v.ch0; cfg_ch1 = v.ch1; cfg_ch2 = v.ch2; thresh = v.th;
        exp_q.push_back({2'd0, v.s0});
        exp_q.push_back({2'd1, v.s1});
        exp_q.push_back({2'd2, v.s2});
        cs_low_cnt = 0; rv_cnt = 0; done_cnt = 0;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        tdone = -1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (scan_done) begin
                tdone = cyc;
                break;
            end
        end
        if (tdone < 0) check($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
        check($sformatf("v%0d_done_time", idx), tdone - t0, 1 + 130 * CLK_DIV);
        check($sformatf("v%0d_cs_low", idx), cs_low_cnt, 130 * CLK_DIV);
        check($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d_cs_at_done", idx), {31'd0, adc_cs_n}, 32'd1);
        check($sformatf("v%0d_sample0", idx), {20'd0, sample0}, {20'd0, v.s0});
        check($sformatf("v%0d_sample1", idx), {20'd0, sample1}, {20'd0, v.s1});
        check($sformatf("v%0d_sample2", idx), {20'd0, sample2}, {20'd0, v.s2});
        check_lb($sformatf("v%0d_line_bits", idx), v.lb);
        tick();
        check($sformatf("v%0d_busy_after", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_rv_cnt", idx), rv_cnt, 3);
        check($sformatf("v%0d_exp_left", idx), exp_q.size(), 0);
        check($sformatf("v%0d_sck_rises", idx), rise_cnt, 64);
        check($sformatf("v%0d_frames", idx), dec_q.size(), 4);
        exp_addr[0] = v.ch0; exp_addr[1] = v.ch1; exp_addr[2] = v.ch2; exp_addr[3] = v.ch0;
        if (dec_q.size() == 4) begin
            for (int f = 0; f < 4; f++)
                check($sformatf("v%0d_addr_f%0d", idx, f), {29'd0, dec_q[f]}, {29'd0, exp_addr[f]});
        end
        exp_q.delete();
    endtask

    int t0, last_done, hi_run, gap_checks, busy_low, bad;
    logic [11:0] es0, es1, es2;
    logic [2:0]  elb;

    initial begin
        vecs[0] = '{3'd5, 3'd6, 3'd7, 12'h6FF, 12'h5DA, 12'h6DA, 12'h7DA, 3'b100};
        vecs[1] = '{3'd0, 3'd1, 3'd2, 12'h0DA, 12'h0DA, 12'h1DA, 12'h2DA, 3'b110};
        vecs[2] = '{3'd7, 3'd3, 3'd0, 12'h0D9, 12'h7DA, 12'h3DA, 12'h0DA, 3'b111};
        vecs[3] = '{3'd4, 3'd4, 3'd6, 12'hFFF, 12'h4DA, 12'h4DA, 12'h6DA, 3'b000};

        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        cfg_ch0 = 3'd0; cfg_ch1 = 3'd0; cfg_ch2 = 3'd0; thresh = 12'd0;
        cs_low_cnt = 0; rv_cnt = 0; done_cnt = 0;
        repeat (3) tick();
        check("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
        check("rst_sck", {31'd0, adc_sck}, 32'd1);
        check("rst_din", {31'd0, adc_din}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pulses", {30'd0, result_valid, scan_done}, 32'd0);
        check("rst_result", {18'd0, result_slot, result_data}, 32'd0);
        check("rst_samples", {sample2[7:0], sample1, sample0}, 32'd0);
        check("rst_line_bits", {29'd0, line_bits}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_start", {30'd0, adc_cs_n, busy}, 32'd2);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // start pulses while busy are dropped
        cfg_ch0 = 3'd3; cfg_ch1 = 3'd1; cfg_ch2 = 3'd6;
        exp_q.push_back({2'd0, 12'h3DA});
        exp_q.push_back({2'd1, 12'h1DA});
        exp_q.push_back({2'd2, 12'h6DA});
        rv_cnt = 0; done_cnt = 0;
        t0 = cyc;
        start = 1'b1;
        tick();
        for (int i = 0; i < 2800; i++) begin
            start = ((cyc - t0) == 5) || ((cyc - t0) == 600);
            tick();
        end
        start = 1'b0;
        check("busy_start_done_cnt", done_cnt, 1);
        check("busy_start_rv_cnt", rv_cnt, 3);
        check("busy_start_sample1", {20'd0, sample1}, 32'h1DA);
        check("busy_start_idle", {31'd0, busy}, 32'd0);
        exp_q.delete();

        // continuous: three scans, cfg changed during the first
        cfg_ch0 = 3'd1; cfg_ch1 = 3'd2; cfg_ch2 = 3'd3; thresh = 12'h2FF;
        exp_q.push_back({2'd0, 12'h1DA}); exp_q.push_back({2'd1, 12'h2DA}); exp_q.push_back({2'd2, 12'h3DA});
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back({2'd0, 12'h4DA}); exp_q.push_back({2'd1, 12'h5DA}); exp_q.push_back({2'd2, 12'h6DA});
        end
        rv_cnt = 0; done_cnt = 0; hi_run = 0; gap_checks = 0; busy_low = 0; last_done = 0;
        continuous = 1'b1;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6000 && done_cnt < 3; i++) begin
            if (cyc - t0 == 500) begin
                cfg_ch0 = 3'd4; cfg_ch1 = 3'd5; cfg_ch2 = 3'd6;
            end
            if (done_cnt == 2 && continuous && (cyc - last_done) > 300) continuous = 1'b0;
            tick();
            if (!busy) busy_low++;
            if (adc_cs_n) begin
                hi_run++;
            end else begin
                if (hi_run > 0) begin
                    check("cont_gap", hi_run, CLK_DIV);
                    gap_checks++;
                end
                hi_run = 0;
            end
            if (scan_done) begin
                last_done = cyc;
                if (done_cnt == 1) begin
                    es0 = 12'h1DA; es1 = 12'h2DA; es2 = 12'h3DA; elb = 3'b100;
                end else begin
                    es0 = 12'h4DA; es1 = 12'h5DA; es2 = 12'h6DA; elb = 3'b111;
                end
                check($sformatf("cont%0d_sample0", done_cnt), {20'd0, sample0}, {20'd0, es0});
                check($sformatf("cont%0d_sample1", done_cnt), {20'd0, sample1}, {20'd0, es1});
                check($sformatf("cont%0d_sample2", done_cnt), {20'd0, sample2}, {20'd0, es2});
                check_lb($sformatf("cont%0d_line_bits", done_cnt), elb);
            end
        end
        check("cont_done_cnt", done_cnt, 3);
        check("cont_gap_checks", gap_checks, 2);
        check("cont_busy_low", busy_low, 0);
        check("cont_rv_cnt", rv_cnt, 9);
        tick();
        check("cont_busy_after", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            tick();
            if (!adc_cs_n) bad++;
        end
        check("cont_stopped", bad + done_cnt, 3);
        exp_q.delete();

        // reset mid-scan, then a full scan from scratch
        cfg_ch0 = 3'd2; cfg_ch1 = 3'd3; cfg_ch2 = 3'd4;
        rv_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (399) tick();
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
        check("mid_rst_sck", {31'd0, adc_sck}, 32'd1);
        check("mid_rst_din_busy", {30'd0, adc_din, busy}, 32'd0);
        check("mid_rst_samples", {8'd0, sample0, sample2}, 32'd0);
        check("mid_rst_line_bits", {29'd0, line_bits}, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (adc_sck !== 1'b1 || adc_cs_n !== 1'b1) bad++;
        end
        check("mid_rst_no_sck", bad, 0);
        rst_n = 1'b1;
        tick();
        run_vec(vecs[0], 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
